blink_scheduler: RTL and testbench

- Sequences the board status outputs D1, D2, DSR and CTS from a prescaled, software-loadable tick counter.
- Replaces the free-running counter-bit LED drive with a controlled one-hot walk through four phases.
- Supports start/stop handshake, periodic or one-shot mode and a clean stop at a phase boundary.
- Sits between the top level (CLKIN domain, 12 MHz) and the status pins.

---
 rtl/blink_scheduler.sv | 145 ++++++++++++++
 tb/tb_blink_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/blink_scheduler.sv
// rtl/blink_scheduler.sv - one-hot status output walk driven by a prescaled phase counter (optional pause: BLINK_SCHED_PAUSE_EN)
module blink_scheduler #(
    parameter int WIDTH  = 26,
    parameter int NPHASE = 4
) (
    input  logic                      CLK,
    input  logic                      RESETN,
    input  logic                      START,
    input  logic                      STOP,
    input  logic                      ONESHOT,
    input  logic [WIDTH-1:0]          DIV,
`ifdef BLINK_SCHED_PAUSE_EN
    input  logic                      PAUSE,
`endif
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      TICK,
    output logic [$clog2(NPHASE)-1:0] PHASE,
    output logic                      D1,
    output logic                      D2,
    output logic                      DSR,
    output logic                      CTS
);

    localparam int PW = $clog2(NPHASE);
    localparam logic [PW-1:0]     LAST_PHASE = PW'(NPHASE - 1);
    localparam logic [NPHASE-1:0] ONE_HOT0   = NPHASE'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic               mode_q, mode_d;
    logic [PW-1:0]      phase_q, phase_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tick_q, tick_d;
    logic [NPHASE-1:0]  leds_q, leds_d;

    logic               run_en;
    logic               terminal;
    logic               finish;

`ifdef BLINK_SCHED_PAUSE_EN
    assign run_en = !PAUSE;
`else
    assign run_en = 1'b1;
`endif

    assign terminal = (cnt_q == div_q - WIDTH'(1));
    // A terminal count ends the walk when stopping, on a fresh stop, or at the end of a one-shot pass
    assign finish   = (state_q == S_STOPPING) || STOP || (mode_q && (phase_q == LAST_PHASE));

    // State register and all registered outputs
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= WIDTH'(1);
            mode_q  <= 1'b0;
            phase_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tick_q  <= 1'b0;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tick_q  <= tick_d;
            leds_q  <= leds_d;
        end
    end

    // Next-state and next-output logic; DONE and TICK default low so they only ever pulse
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        mode_d  = mode_q;
        phase_d = phase_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tick_d  = 1'b0;
        leds_d  = leds_q;
        case (state_q)
            S_IDLE: begin
                if (START && !STOP) begin
                    div_d   = (DIV == '0) ? WIDTH'(1) : DIV;
                    mode_d  = ONESHOT;
                    cnt_d   = '0;
                    phase_d = '0;
                    busy_d  = 1'b1;
                    leds_d  = ONE_HOT0;
                    state_d = S_RUN;
                end
            end
            S_RUN, S_STOPPING: begin
                if (run_en && terminal) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    if (finish) begin
                        state_d = S_IDLE;
                        phase_d = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        leds_d  = '0;
                    end else begin
                        phase_d = phase_q + PW'(1);
                        leds_d  = ONE_HOT0 << phase_d;
                    end
                end else begin
                    if (run_en) begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                    if (state_q == S_RUN && STOP) begin
                        state_d = S_STOPPING;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign TICK  = tick_q;
    assign PHASE = phase_q;
    assign D1    = leds_q[0];
    assign D2    = leds_q[1];
    assign DSR   = leds_q[2];
    assign CTS   = leds_q[3];

endmodule

// File: tb/tb_blink_scheduler.sv
// tb/tb_blink_scheduler.sv - table-driven and directed checks for blink_scheduler (pause sequence under BLINK_SCHED_PAUSE_EN)
module tb_blink_scheduler;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        stop;
    logic        oneshot;
    logic [25:0] div;
`ifdef BLINK_SCHED_PAUSE_EN
    logic        pause;
`endif
    logic        busy;
    logic        done;
    logic        tick;
    logic [1:0]  phase;
    logic        d1;
    logic        d2;
    logic        dsr;
    logic        cts;

    int checks;
    int failures;

    typedef struct {
        logic        rstn;
        logic        start;
        logic        stop;
        logic        oneshot;
        logic [25:0] div;
        logic [8:0]  exp;
    } vec_t;

    vec_t tbl[$];

    blink_scheduler #(.WIDTH(26), .NPHASE(4)) dut (
        .CLK     (clk),
        .RESETN  (resetn),
        .START   (start),
        .STOP    (stop),
        .ONESHOT (oneshot),
        .DIV     (div),
`ifdef BLINK_SCHED_PAUSE_EN
        .PAUSE   (pause),
`endif
        .BUSY    (busy),
        .DONE    (done),
        .TICK    (tick),
        .PHASE   (phase),
        .D1      (d1),
        .D2      (d2),
        .DSR     (dsr),
        .CTS     (cts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] pack_exp(input logic b, input logic dn, input logic t, input logic [1:0] ph);
        logic [3:0] leds;
        leds = b ? (4'b0001 << ph) : 4'b0000;
        return {b, dn, t, ph, leds};
    endfunction

    function automatic logic [8:0] observed();
        return {busy, done, tick, phase, cts, dsr, d2, d1};
    endfunction

    task automatic add(input logic r, input logic s, input logic p, input logic o, input logic [25:0] d,
                       input logic b, input logic dn, input logic t, input logic [1:0] ph);
        vec_t v;
        v.rstn    = r;
        v.start   = s;
        v.stop    = p;
        v.oneshot = o;
        v.div     = d;
        v.exp     = pack_exp(b, dn, t, ph);
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {busy,done,tick,phase,cts,dsr,d2,d1}=%b required %b", name, act, exp);
        end
    endtask

    task automatic step_chk(input string name, input logic b, input logic dn, input logic t, input logic [1:0] ph);
        @(posedge clk);
        #1;
        check(name, observed(), pack_exp(b, dn, t, ph));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        start    = 1'b1;
        stop     = 1'b0;
        oneshot  = 1'b0;
        div      = 26'd3;
`ifdef BLINK_SCHED_PAUSE_EN
        pause    = 1'b0;
`endif

        // Reset held with START high, then a periodic DIV=3 walk; DIV changes after start must not matter
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 26'd3, 1'b0, 1'b0, 1'b0, 2'd0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 26'd3, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int j = 1; j <= 20; j++)
            add(1'b1, (j < 3), 1'b0, 1'b0, (j < 5) ? 26'd3 : 26'd7,
                1'b1, 1'b0, (j % 3 == 0), 2'((j / 3) % 4));
        // STOP on the terminal cycle: immediate IDLE with DONE and TICK
        add(1'b1, 1'b0, 1'b1, 1'b0, 26'd3, 1'b0, 1'b1, 1'b1, 2'd0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 26'd3, 1'b0, 1'b0, 1'b0, 2'd0);
        // START and STOP together in IDLE: stays idle
        add(1'b1, 1'b1, 1'b1, 1'b0, 26'd3, 1'b0, 1'b0, 1'b0, 2'd0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 26'd3, 1'b0, 1'b0, 1'b0, 2'd0);
        // One-shot DIV=2: ticks at 2,4,6,8, DONE at 8; ONESHOT dropped after start is ignored
        add(1'b1, 1'b1, 1'b0, 1'b1, 26'd2, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int j = 1; j <= 7; j++)
            add(1'b1, 1'b0, 1'b0, 1'b0, 26'd2, 1'b1, 1'b0, (j % 2 == 0), 2'(j / 2));
        add(1'b1, 1'b0, 1'b0, 1'b0, 26'd2, 1'b0, 1'b1, 1'b1, 2'd0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 26'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        // DIV=0 behaves as DIV=1: phase advances every cycle
        add(1'b1, 1'b1, 1'b0, 1'b0, 26'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int j = 1; j <= 5; j++)
            add(1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 1'b1, 1'b0, 1'b1, 2'(j % 4));
        // Reset mid-run clears everything without DONE
        add(1'b0, 1'b0, 1'b0, 1'b0, 26'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 1'b0, 1'b0, 1'b0, 2'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            resetn  = tbl[i].rstn;
            start   = tbl[i].start;
            stop    = tbl[i].stop;
            oneshot = tbl[i].oneshot;
            div     = tbl[i].div;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), observed(), tbl[i].exp);
        end

        // Asynchronous reset takes effect without a clock edge
        start = 1'b1; div = 26'd5;
        step_chk("async_start", 1'b1, 1'b0, 1'b0, 2'd0);
        start = 1'b0;
        step_chk("async_run", 1'b1, 1'b0, 1'b0, 2'd0);
        resetn = 1'b0;
        #2;
        check("async_clear", observed(), pack_exp(1'b0, 1'b0, 1'b0, 2'd0));
        step_chk("async_no_done", 1'b0, 1'b0, 1'b0, 2'd0);
        resetn = 1'b1;

        // Stop mid-phase at cnt=1 of phase 1 with DIV=5; START during STOPPING ignored
        start = 1'b1; div = 26'd5;
        step_chk("stp_start", 1'b1, 1'b0, 1'b0, 2'd0);
        start = 1'b0;
        for (int j = 1; j <= 4; j++) step_chk($sformatf("stp_p0_%0d", j), 1'b1, 1'b0, 1'b0, 2'd0);
        step_chk("stp_tick1", 1'b1, 1'b0, 1'b1, 2'd1);
        step_chk("stp_cnt1", 1'b1, 1'b0, 1'b0, 2'd1);
        stop = 1'b1;
        step_chk("stp_enter", 1'b1, 1'b0, 1'b0, 2'd1);
        stop = 1'b0; start = 1'b1; div = 26'd2;
        step_chk("stp_cnt3", 1'b1, 1'b0, 1'b0, 2'd1);
        step_chk("stp_cnt4", 1'b1, 1'b0, 1'b0, 2'd1);
        step_chk("stp_done", 1'b0, 1'b1, 1'b1, 2'd0);
        start = 1'b0;
        step_chk("stp_idle", 1'b0, 1'b0, 1'b0, 2'd0);

`ifdef BLINK_SCHED_PAUSE_EN
        // PAUSE at cnt=2 with DIV=4 freezes the walk; next TICK two cycles after release
        start = 1'b1; div = 26'd4;
        step_chk("pz_start", 1'b1, 1'b0, 1'b0, 2'd0);
        start = 1'b0;
        step_chk("pz_cnt1", 1'b1, 1'b0, 1'b0, 2'd0);
        step_chk("pz_cnt2", 1'b1, 1'b0, 1'b0, 2'd0);
        pause = 1'b1;
        for (int j = 0; j < 10; j++) step_chk($sformatf("pz_hold%0d", j), 1'b1, 1'b0, 1'b0, 2'd0);
        pause = 1'b0;
        step_chk("pz_cnt3", 1'b1, 1'b0, 1'b0, 2'd0);
        step_chk("pz_tick", 1'b1, 1'b0, 1'b1, 2'd1);
        resetn = 1'b0;
        step_chk("pz_reset", 1'b0, 1'b0, 1'b0, 2'd0);
        resetn = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
